// File: rtl/alu_pkg.sv
// Shared definitions for the ALU BIST sequencer: ALU op codes, the
// sequencer state type and the four fixed operand pairs of the vector set.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [31:0] PAIR0_A = 32'hA5A5_A5A5;
  localparam logic [31:0] PAIR0_B = 32'h5A5A_5A5A;
  localparam logic [31:0] PAIR1_A = 32'h0123_4567;
  localparam logic [31:0] PAIR1_B = 32'h7654_3210;
  localparam logic [31:0] PAIR2_A = 32'h7FFF_FFFF;
  localparam logic [31:0] PAIR2_B = 32'h0000_0001;
  localparam logic [31:0] PAIR3_A = 32'h0000_0000;
  localparam logic [31:0] PAIR3_B = 32'h0000_0000;

  // Operand A of the given pair.
  function automatic logic [31:0] pair_a(input logic [1:0] pair);
    logic [31:0] a;
    case (pair)
      2'd0:    a = PAIR0_A;
      2'd1:    a = PAIR1_A;
      2'd2:    a = PAIR2_A;
      2'd3:    a = PAIR3_A;
      default: a = 32'h0000_0000;
    endcase
    return a;
  endfunction

  // Operand B of the given pair.
  function automatic logic [31:0] pair_b(input logic [1:0] pair);
    logic [31:0] b;
    case (pair)
      2'd0:    b = PAIR0_B;
      2'd1:    b = PAIR1_B;
      2'd2:    b = PAIR2_B;
      2'd3:    b = PAIR3_B;
      default: b = 32'h0000_0000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU used as the golden model by alu_bist.
// Overflow is the two's-complement signed overflow for ADD/SUB, 0 otherwise.
module alu_golden
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] res_o,
  output logic        zero_o,
  output logic        overflow_o
);

  logic [31:0] sum_s;
  logic [31:0] diff_s;
  logic        add_ovf_s;
  logic        sub_ovf_s;
  logic        slt_s;

  assign sum_s     = a_i + b_i;
  assign diff_s    = a_i - b_i;
  // Same-sign operands producing a different-sign sum overflow.
  assign add_ovf_s = (a_i[31] == b_i[31]) && (sum_s[31] != a_i[31]);
  // Different-sign operands whose difference flips away from A overflow.
  assign sub_ovf_s = (a_i[31] != b_i[31]) && (diff_s[31] != a_i[31]);
  assign slt_s     = ($signed(a_i) < $signed(b_i));

  // Select the result and overflow flag for the requested operation.
  always_comb begin
    res_o      = 32'h0000_0000;
    overflow_o = 1'b0;
    case (op_i)
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_ADD: begin
        res_o      = sum_s;
        overflow_o = add_ovf_s;
      end
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_NOR: res_o = ~(a_i | b_i);
      ALU_SRL: res_o = a_i >> b_i[4:0];
      ALU_SUB: begin
        res_o      = diff_s;
        overflow_o = sub_ovf_s;
      end
      ALU_SLT: res_o = {31'h0000_0000, slt_s};
      default: begin
        res_o      = 32'h0000_0000;
        overflow_o = 1'b0;
      end
    endcase
  end

  assign zero_o = (res_o == 32'h0000_0000);

endmodule

// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the ALU datapath. Drives a fixed set of
// 32 vectors (4 operand pairs x 8 ops), compares the ALU against alu_golden
// and reports pass/fail, error count and first failing vector index.
// Optional feature: define ALU_BIST_STOP_ON_FAIL_EN to end the run at the
// first mismatching vector instead of running all 32.
module alu_bist
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_cnt,
  output logic [4:0]  fail_vec,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_overflow
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [4:0] LAST_IDX  = 5'd31;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [5:0]  err_q, err_d;
  logic [4:0]  fail_q, fail_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [31:0] gold_res_s;
  logic        gold_zero_s;
  logic        gold_ovf_s;
  logic        mismatch_s;
  logic        finish_s;
  logic [4:0]  next_idx_s;

  alu_golden u_golden (
    .a_i        (alu_a_q),
    .b_i        (alu_b_q),
    .op_i       (alu_op_q),
    .res_o      (gold_res_s),
    .zero_o     (gold_zero_s),
    .overflow_o (gold_ovf_s)
  );

  assign mismatch_s = (alu_res != gold_res_s) || (alu_zero != gold_zero_s) ||
                      (alu_overflow != gold_ovf_s);
  assign next_idx_s = idx_q + 5'd1;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
  assign finish_s = (idx_q == LAST_IDX) || mismatch_s;
`else
  assign finish_s = (idx_q == LAST_IDX);
`endif

  // Next-state, vector sequencing and result accumulation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    err_d    = err_q;
    fail_d   = fail_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d    = 6'd0;
          fail_d   = 5'd0;
          idx_d    = 5'd0;
          alu_a_d  = pair_a(2'd0);
          alu_b_d  = pair_b(2'd0);
          alu_op_d = 3'b111;
          cnt_d    = SETTLE_LD;
          state_d  = ST_SETTLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_SETTLE: begin
        // The counter holds the settle cycles left including this one.
        if (cnt_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          err_d = err_q + 6'd1;
          if (err_q == 6'd0) begin
            fail_d = idx_q;
          end else begin
            fail_d = fail_q;
          end
        end else begin
          err_d = err_q;
        end
        if (finish_s) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = next_idx_s;
          alu_a_d  = pair_a(next_idx_s[4:3]);
          alu_b_d  = pair_b(next_idx_s[4:3]);
          alu_op_d = ~next_idx_s[2:0];
          cnt_d    = SETTLE_LD;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags follow the next state so they are registered with it.
  always_comb begin
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_d == 6'd0);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= 5'd0;
      alu_a_q  <= 32'h0000_0000;
      alu_b_q  <= 32'h0000_0000;
      alu_op_q <= 3'b000;
      err_q    <= 6'd0;
      fail_q   <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;
  assign alu_A    = alu_a_q;
  assign alu_B    = alu_b_q;
  assign alu_op   = alu_op_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a behavioural ALU with injectable faults
// drives the DUT, and expected results are derived from the vector table.
module tb_alu_bist;

  localparam int S  = 1;
  localparam int S3 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start3;
  logic        busy, done, pass, busy3, done3, pass3;
  logic [5:0]  err_cnt, err_cnt3;
  logic [4:0]  fail_vec, fail_vec3;
  logic [31:0] alu_A, alu_B, alu_res, alu_A3, alu_B3, alu_res3;
  logic [2:0]  alu_op, alu_op3;
  logic        alu_zero, alu_overflow, alu_zero3, alu_overflow3;

  logic [31:0] fault_mask;
  logic        fault_ovf0;

  logic [31:0] PA [4];
  logic [31:0] PB [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_bist #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec), .alu_A(alu_A), .alu_B(alu_B),
    .alu_op(alu_op), .alu_res(alu_res), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow)
  );

  alu_bist #(.SETTLE_CYCLES(S3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err_cnt3), .fail_vec(fail_vec3), .alu_A(alu_A3), .alu_B(alu_B3),
    .alu_op(alu_op3), .alu_res(alu_res3), .alu_zero(alu_zero3),
    .alu_overflow(alu_overflow3)
  );

  // Reference ALU from plain integer arithmetic: returns {overflow, result}.
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    longint sa, sb, r;
    logic [31:0] res;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 1'b0;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: begin r = sa + sb; res = 32'(r); ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'd3: res = a ^ b;
      3'd4: res = ~(a | b);
      3'd5: res = a >> b[4:0];
      3'd6: begin r = sa - sb; res = 32'(r); ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      default: res = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    return {ovf, res};
  endfunction

  // Vector index implied by the operands currently presented.
  function automatic int vec_of(input logic [31:0] a, input logic [2:0] op);
    int p;
    logic [2:0] slot;
    if (a == 32'hA5A5A5A5) p = 0;
    else if (a == 32'h01234567) p = 1;
    else if (a == 32'h7FFFFFFF) p = 2;
    else p = 3;
    slot = ~op;
    return p * 8 + int'(slot);
  endfunction

  logic [32:0] r1, r3;
  always_comb begin
    r1 = ref_alu(alu_A, alu_B, alu_op);
    alu_res = r1[31:0] ^ (fault_mask[vec_of(alu_A, alu_op)] ? 32'h1 : 32'h0);
    alu_zero = (alu_res == 32'h0);
    alu_overflow = fault_ovf0 ? 1'b0 : r1[32];
    r3 = ref_alu(alu_A3, alu_B3, alu_op3);
    alu_res3 = r3[31:0];
    alu_zero3 = (r3[31:0] == 32'h0);
    alu_overflow3 = r3[32];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run on u_dut with a fault setting; optional ignored start re-pulse.
  task automatic do_run(input int repulse_at, input logic [31:0] mask, input logic ovf0);
    logic [31:0] bad;
    logic [32:0] r;
    logic [4:0] vi;
    int exp_err, exp_fail, exp_cyc, cyc, v;
    fault_mask = mask;
    fault_ovf0 = ovf0;
    bad = 32'h0;
    for (int i = 0; i < 32; i++) begin
      vi = 5'(i);
      r = ref_alu(PA[i/8], PB[i/8], ~vi[2:0]);
      bad[i] = mask[i] | (ovf0 & r[32]);
    end
    exp_err = $countones(bad);
    exp_fail = 0;
    for (int i = 31; i >= 0; i--) if (bad[i]) exp_fail = i;
    exp_cyc = 32 * (S + 1);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    if (exp_err != 0) begin
      exp_err = 1;
      exp_cyc = (exp_fail + 1) * (S + 1);
    end
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_edge_done", {63'd0, done}, 64'd0);
    cyc = 0;
    while (busy && cyc < 2000) begin
      v = cyc / (S + 1);
      vi = 5'(v);
      chk("vec_A", {32'd0, alu_A}, {32'd0, PA[v/8]});
      chk("vec_B", {32'd0, alu_B}, {32'd0, PB[v/8]});
      chk("vec_op", {61'd0, alu_op}, {61'd0, ~vi[2:0]});
      if (cyc == repulse_at) start = 1'b1;
      cyc++;
      tick();
      start = 1'b0;
    end
    chk("run_cycles", 64'(cyc), 64'(exp_cyc));
    chk("done", {63'd0, done}, 64'd1);
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("err_cnt", {58'd0, err_cnt}, 64'(exp_err));
    chk("fail_vec", {59'd0, fail_vec}, 64'(exp_fail));
    chk("pass", {63'd0, pass}, (exp_err == 0) ? 64'd1 : 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
    chk({tag, "_err"}, {58'd0, err_cnt}, 64'd0);
    chk({tag, "_fail"}, {59'd0, fail_vec}, 64'd0);
    chk({tag, "_A"}, {32'd0, alu_A}, 64'd0);
    chk({tag, "_B"}, {32'd0, alu_B}, 64'd0);
    chk({tag, "_op"}, {61'd0, alu_op}, 64'd0);
  endtask

  initial begin
    int cyc;
    logic [4:0] vi;
    PA = '{32'hA5A5A5A5, 32'h01234567, 32'h7FFFFFFF, 32'h00000000};
    PB = '{32'h5A5A5A5A, 32'h76543210, 32'h00000001, 32'h00000000};
    fault_mask = 32'h0;
    fault_ovf0 = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Clean run, then overflow stuck at zero (vectors 1 and 21 fail).
    do_run(-1, 32'h0, 1'b0);
    do_run(-1, 32'h0, 1'b1);

    // Randomized sparse result faults, some combined with the overflow fault.
    for (int k = 0; k < 6; k++) begin
      do_run(-1, $urandom & $urandom & $urandom, 1'($urandom_range(0, 1)));
    end

    // Ignored re-pulse mid-run, then restart directly from DONE.
    do_run(10, 32'h0, 1'b0);
    do_run(-1, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a run.
    fault_mask = 32'h0;
    fault_ovf0 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #2 rst = 1'b1;
    #1;
    chk_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_zero("after_rst");
    do_run(-1, 32'h0, 1'b0);

    // Longer settle time: operands change every four cycles, 128-cycle run.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 0;
    while (busy3 && cyc < 2000) begin
      vi = 5'(cyc / (S3 + 1));
      chk("s3_op", {61'd0, alu_op3}, {61'd0, ~vi[2:0]});
      chk("s3_A", {32'd0, alu_A3}, {32'd0, PA[vi[4:3]]});
      cyc++;
      tick();
    end
    chk("s3_cycles", 64'(cyc), 64'd128);
    chk("s3_done", {63'd0, done3}, 64'd1);
    chk("s3_pass", {63'd0, pass3}, 64'd1);
    chk("s3_err", {58'd0, err_cnt3}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
